cpu_control: RTL and testbench

Instruction register, decoder and control FSM that drives the 16-bit register-file/ALU datapath. It is the other end of the datapath control interface. It accepts a 16-bit instruction, sequences the datapath's load, select and write strobes cycle by cycle, and signals completion. A top-level CPU instantiates it alongside the datapath, with every control output wired one-to-one to the matching datapath input.

---
 rtl/cpu_control_if.sv | 33 +++
 rtl/cpu_control.sv | 121 ++++++++++++
 tb/tb_cpu_control.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_if.sv
// rtl/cpu_control_if.sv - instruction/handshake and datapath control bundle for cpu_control
interface cpu_control_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;

    modport slave (
        input  in, load, s,
        output w, sximm8, sximm5, readnum, writenum, write, vsel,
               loada, loadb, loadc, loads, asel, bsel, shift, ALUop
    );

    modport master (
        output in, load, s,
        input  w, sximm8, sximm5, readnum, writenum, write, vsel,
               loada, loadb, loadc, loads, asel, bsel, shift, ALUop
    );
endinterface

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - instruction register, decoder and Moore control FSM for the register-file/ALU datapath
module cpu_control (
    input  logic          clk,
    input  logic          reset,
    cpu_control_if.slave  bus
);
    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WR_IMM,
        S_WR_REG
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;
    logic [1:0] sh;
    logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
    assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        bus.w        = 1'b0;
        bus.readnum  = 3'b000;
        bus.writenum = 3'b000;
        bus.write    = 1'b0;
        bus.vsel     = 2'b00;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;

        case (state_q)
            S_WAIT: begin
                bus.w = 1'b1;
                // IR capture and start may share an edge; DECODE then sees the new word
                if (bus.load) ir_d = bus.in;
                if (bus.s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)               state_d = S_WR_IMM;
                else if (is_mov_reg || is_mvn) state_d = S_GET_B;
                else if (is_alu)              state_d = S_GET_A;
                else                          state_d = S_WAIT;
            end
            S_GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_d     = S_GET_B;
            end
            S_GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                bus.shift   = sh;
                state_d     = S_ALU;
            end
            S_ALU: begin
                // single-operand forms pass B through the ALU with A forced to zero
                bus.asel  = is_mov_reg || is_mvn;
                bus.shift = sh;
                bus.ALUop = is_alu ? op : 2'b00;
                if (is_cmp) begin
                    bus.loads = 1'b1;
                    state_d   = S_WAIT;
                end else begin
                    bus.loadc = 1'b1;
                    state_d   = S_WR_REG;
                end
            end
            S_WR_REG: begin
                bus.writenum = rd;
                bus.vsel     = 2'b00;
                bus.write    = 1'b1;
                state_d      = S_WAIT;
            end
            S_WR_IMM: begin
                bus.writenum = rn;
                bus.vsel     = 2'b01;
                bus.write    = 1'b1;
                state_d      = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end
endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - cpu_control driving a behavioural datapath, checked against an ISA-level reference
module tb_cpu_control;
    logic clk;
    logic reset;
    logic dp_clr;
    int   tests;
    int   fails;

    cpu_control_if bus ();

    cpu_control u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] sh);
        case (sh)
            2'b01:   return x << 1;
            2'b10:   return x >> 1;
            2'b11:   return {x[15], x[15:1]};
            default: return x;
        endcase
    endfunction

    // Behavioural datapath: consumes the control strobes exactly as a top-level CPU would
    logic [15:0] rf [8];
    logic [15:0] ra, rb, rc;
    logic        z, n, v;
    logic [15:0] dp_ain, dp_bin, dp_out;
    logic        dp_v;

    always_comb begin
        dp_ain = bus.asel ? 16'h0000 : ra;
        dp_bin = bus.bsel ? bus.sximm5 : shf(rb, bus.shift);
        case (bus.ALUop)
            2'b00:   dp_out = dp_ain + dp_bin;
            2'b01:   dp_out = dp_ain - dp_bin;
            2'b10:   dp_out = dp_ain & dp_bin;
            default: dp_out = ~dp_bin;
        endcase
        dp_v = (dp_ain[15] != dp_bin[15]) && (dp_out[15] != dp_ain[15]);
    end

    always @(posedge clk) begin
        if (dp_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            ra <= '0; rb <= '0; rc <= '0;
            z <= 1'b0; n <= 1'b0; v <= 1'b0;
        end else begin
            if (bus.write) rf[bus.writenum] <= (bus.vsel == 2'b01) ? bus.sximm8 : rc;
            if (bus.loada) ra <= rf[bus.readnum];
            if (bus.loadb) rb <= rf[bus.readnum];
            if (bus.loadc) rc <= dp_out;
            if (bus.loads) begin
                z <= (dp_out == 16'h0000);
                n <= dp_out[15];
                v <= dp_v;
            end
        end
    end

    // ISA-level reference: architectural registers and flags
    logic [15:0] ref_r [8];
    logic        ref_z, ref_n, ref_v;

    localparam int LAT   [7] = '{3, 5, 6, 5, 6, 5, 2};
    localparam int NWR   [7] = '{1, 1, 1, 0, 1, 1, 0};
    localparam int NLDA  [7] = '{0, 0, 1, 1, 1, 0, 0};
    localparam int NLDB  [7] = '{0, 1, 1, 1, 1, 1, 0};

    // 0 MOV imm, 1 MOV reg, 2 ADD, 3 CMP, 4 AND, 5 MVN, 6 illegal
    function automatic int classify(input logic [15:0] wd);
        if (wd[15:13] == 3'b110) begin
            if (wd[12:11] == 2'b10) return 0;
            if (wd[12:11] == 2'b00) return 1;
            return 6;
        end
        if (wd[15:13] == 3'b101) return 2 + int'(wd[12:11]);
        return 6;
    endfunction

    task automatic ref_exec(input logic [15:0] wd);
        logic [15:0] bm, diff, an;
        bm = shf(ref_r[wd[2:0]], wd[4:3]);
        an = ref_r[wd[10:8]];
        case (classify(wd))
            0: ref_r[wd[10:8]] = {{8{wd[7]}}, wd[7:0]};
            1: ref_r[wd[7:5]]  = bm;
            2: ref_r[wd[7:5]]  = an + bm;
            3: begin
                diff  = an - bm;
                ref_z = (diff == 16'h0000);
                ref_n = diff[15];
                ref_v = (an[15] != bm[15]) && (diff[15] != an[15]);
            end
            4: ref_r[wd[7:5]]  = an & bm;
            5: ref_r[wd[7:5]]  = ~bm;
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [15:0] wd, input bit together, input bit noise);
        int k, lo, wr, la, lb;
        logic [1:0] vs;
        k = classify(wd);
        lo = 0; wr = 0; la = 0; lb = 0; vs = 2'b00;
        @(negedge clk);
        bus.in = wd; bus.load = 1'b1; bus.s = together;
        if (!together) begin
            @(negedge clk);
            bus.load = 1'b0; bus.s = 1'b1;
        end
        @(negedge clk);
        bus.s = 1'b0;
        bus.load = noise;
        if (noise) bus.in = 16'hD6AA;
        for (int i = 0; i < 20; i++) begin
            if (bus.w) break;
            lo++;
            if (bus.write) begin wr++; vs = bus.vsel; end
            if (bus.loada) la++;
            if (bus.loadb) lb++;
            @(negedge clk);
            if (bus.w) bus.load = 1'b0;
        end
        bus.load = 1'b0;
        ref_exec(wd);
        check($sformatf("busy_cycles[%h]", wd), lo, LAT[k] - 1);
        check($sformatf("write_count[%h]", wd), wr, NWR[k]);
        check($sformatf("loada_count[%h]", wd), la, NLDA[k]);
        check($sformatf("loadb_count[%h]", wd), lb, NLDB[k]);
        if (NWR[k] != 0) check($sformatf("vsel[%h]", wd), vs, (k == 0) ? 2'b01 : 2'b00);
        for (int r = 0; r < 8; r++) check($sformatf("R%0d[%h]", r, wd), rf[r], ref_r[r]);
        check($sformatf("flags[%h]", wd), {z, n, v}, {ref_z, ref_n, ref_v});
        check($sformatf("sximm8[%h]", wd), bus.sximm8, {{8{wd[7]}}, wd[7:0]});
        check($sformatf("sximm5[%h]", wd), bus.sximm5, {{11{wd[4]}}, wd[4:0]});
    endtask

    initial begin
        logic [15:0] wd;
        int kind;
        tests = 0; fails = 0;
        reset = 1'b1; dp_clr = 1'b1;
        bus.in = '0; bus.load = 1'b0; bus.s = 1'b0;
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        ref_z = 1'b0; ref_n = 1'b0; ref_v = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; dp_clr = 1'b0;

        check("reset_w", bus.w, 1'b1);
        check("reset_strobes", {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel}, 7'b0);
        check("reset_fields", {bus.readnum, bus.writenum, bus.vsel, bus.shift, bus.ALUop}, 12'b0);
        check("reset_ir", bus.sximm8, 16'h0000);

        run(16'hD007, 1'b0, 1'b0);
        run(16'hD102, 1'b0, 1'b0);
        check("mov_r0", rf[0], 16'h0007);
        check("mov_r1", rf[1], 16'h0002);
        run(16'hA148, 1'b0, 1'b0);
        check("add_r2", rf[2], 16'h0010);
        run(16'hA801, 1'b0, 1'b0);
        check("cmp_r0_r1", {z, n, v}, 3'b000);
        run(16'hA900, 1'b0, 1'b0);
        check("cmp_r1_r0_n", n, 1'b1);
        run(16'hB861, 1'b0, 1'b0);
        check("mvn_r3", rf[3], 16'hFFFD);
        run(16'hD4FF, 1'b0, 1'b0);
        check("mov_neg_r4", rf[4], 16'hFFFF);
        run(16'hA2C1, 1'b0, 1'b1);
        check("busy_load_r6", rf[6], 16'h0012);
        run(16'hE000, 1'b0, 1'b0);

        // reset while ADD R5,R1,R0 sits in ALU
        @(negedge clk);
        bus.in = 16'hA1A0; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0; bus.s = 1'b1;
        @(negedge clk);
        bus.s = 1'b0;
        repeat (3) @(negedge clk);
        check("alu_loadc", bus.loadc, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_w", bus.w, 1'b1);
        check("rst_mid_strobes", {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel}, 7'b0);
        check("rst_mid_ir", bus.sximm8, 16'h0000);
        repeat (2) @(negedge clk);
        check("rst_mid_r5", rf[5], ref_r[5]);
        check("rst_mid_idle", bus.w, 1'b1);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 6);
            wd = 16'($urandom);
            case (kind)
                0: wd[15:11] = 5'b11010;
                1: wd[15:11] = 5'b11000;
                2, 3, 4, 5: wd[15:11] = {3'b101, 2'(kind - 2)};
                default: begin
                    for (int g = 0; g < 100; g++) begin
                        if (classify(wd) == 6) break;
                        wd = 16'($urandom);
                    end
                end
            endcase
            run(wd, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
